tensor_unpacker: RTL and testbench

Downstream stage of the tensor read-address generator. Accepts the same job descriptor (dtype, element count) and captures the memory read words returned for that job into a small word FIFO. Unpacks each word into elements in LSB-first order and emits them one per beat on an AXI-stream-style output with `tlast` on the final element. Exposes an almost-full hint so the address side can be throttled, and flags bad descriptors and overflow.

---
 rtl/tensor_pkg.sv | 47 ++++
 rtl/tensor_word_fifo.sv | 81 ++++++++
 rtl/tensor_unpacker.sv | 186 ++++++++++++++++++
 tb/tb_tensor_unpacker.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tensor_pkg.sv
// -----------------------------------------------------------------------------
// tensor_pkg
// Definitions shared by the tensor read-address generator and the tensor
// unpacker:
//   - dtype_e          : element type codes carried in the job descriptor
//   - CFG_* constants  : bit positions of the fields inside cfg_tdata
//   - lanes_per_word() : how many elements one 32-bit memory word holds
//   - dtype_valid()    : whether a raw dtype code names a supported type
// -----------------------------------------------------------------------------
package tensor_pkg;

    // Descriptor layout: [42:40] dtype code, [39:0] element count.
    localparam int CFG_W         = 43;
    localparam int CFG_DTYPE_MSB = 42;
    localparam int CFG_DTYPE_LSB = 40;
    localparam int CFG_COUNT_MSB = 39;
    localparam int CFG_COUNT_LSB = 0;
    localparam int COUNT_W       = CFG_COUNT_MSB - CFG_COUNT_LSB + 1;
    localparam int DTYPE_W       = CFG_DTYPE_MSB - CFG_DTYPE_LSB + 1;

    // Codes 5..7 are intentionally left unnamed; they are treated as invalid.
    typedef enum logic [DTYPE_W-1:0] {
        DT_NONE  = 3'd0,
        DT_INT8  = 3'd1,
        DT_INT16 = 3'd2,
        DT_INT32 = 3'd3,
        DT_FP32  = 3'd4
    } dtype_e;

    // Elements packed into one 32-bit word; 0 marks an unsupported code.
    function automatic logic [2:0] lanes_per_word(input logic [DTYPE_W-1:0] dtype);
        logic [2:0] lanes;
        case (dtype)
            DT_INT8:  lanes = 3'd4;
            DT_INT16: lanes = 3'd2;
            DT_INT32: lanes = 3'd1;
            DT_FP32:  lanes = 3'd1;
            default:  lanes = 3'd0;
        endcase
        return lanes;
    endfunction

    function automatic logic dtype_valid(input logic [DTYPE_W-1:0] dtype);
        return lanes_per_word(dtype) != 3'd0;
    endfunction

endpackage

// File: rtl/tensor_word_fifo.sv
// -----------------------------------------------------------------------------
// tensor_word_fifo
// Synchronous word FIFO with a first-word fall-through head: the oldest entry
// is always visible on rdata while empty is low, and a word written on one
// edge is visible on the next cycle.
//
// Ports:
//   clock  in   sole clock, rising edge
//   reset  in   synchronous, active-high; empties the FIFO
//   push   in   write request for wdata
//   wdata  in   word to write
//   pop    in   remove the head word (ignored while empty)
//   rdata  out  head word (meaningful only while empty is low)
//   full   out  all DEPTH entries occupied
//   empty  out  no entries occupied
//   count  out  occupancy, 0..DEPTH
//
// A push while full is still taken when a pop happens in the same cycle,
// because the slot freed by the pop absorbs the new word. Otherwise a push
// while full is ignored; the caller is responsible for reporting the loss.
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module tensor_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array carries no reset; validity is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tensor_unpacker.sv
// -----------------------------------------------------------------------------
// tensor_unpacker
// Downstream stage of the tensor read-address generator. Takes the same job
// descriptor as the address side, buffers the returned memory words in a
// small FIFO, and emits the packed elements one per beat, LSB lane first,
// with tlast on the final element of the job.
//
// Ports:
//   clock         in   sole clock, rising edge
//   reset         in   synchronous, active-high
//   cfg_tdata     in   [42:40] dtype code, [39:0] element count
//   cfg_tvalid    in   descriptor valid
//   cfg_tready    out  high only while idle
//   mem_rdata     in   returned read word
//   mem_rvalid    in   read word valid (cannot be back-pressured)
//   fifo_afull    out  throttle hint: occupancy >= FIFO_DEPTH - AFULL_MARGIN
//   out_tdata     out  element, sign-extended (int8/int16) or passed through
//   out_tvalid    out  element valid
//   out_tready    in   downstream ready
//   out_tlast     out  final element of the job
//   err_dtype     out  one-cycle pulse after a rejected descriptor
//   err_overflow  out  sticky: a returned word was dropped; cleared by reset
// -----------------------------------------------------------------------------
module tensor_unpacker
    import tensor_pkg::*;
#(
    parameter int WORD_W       = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int AFULL_MARGIN = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CFG_W-1:0]  cfg_tdata,
    input  logic              cfg_tvalid,
    output logic              cfg_tready,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              fifo_afull,
    output logic [WORD_W-1:0] out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output logic              err_dtype,
    output logic              err_overflow
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OCC_W-1:0] AFULL_LEVEL = OCC_W'(FIFO_DEPTH - AFULL_MARGIN);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Job state.
    logic [0:0]         state;
    dtype_e             dtype_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] elem_cnt;
    logic [1:0]         lane;
    logic               err_dtype_q;
    logic               err_overflow_q;

    // FIFO interface.
    logic               fifo_push;
    logic               fifo_pop;
    logic [WORD_W-1:0]  fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [OCC_W-1:0]   fifo_count;

    // Decoded descriptor and per-beat control.
    logic [DTYPE_W-1:0] cfg_dtype;
    logic [COUNT_W-1:0] cfg_count;
    logic               cfg_ok;
    logic               cfg_fire;
    logic               in_run;
    logic [2:0]         lane_last_idx;
    logic               lane_is_last;
    logic               elem_is_last;
    logic               out_fire;
    logic               word_dropped;
    logic [WORD_W-1:0]  elem_ext;
    logic [7:0]         elem_b;
    logic [15:0]        elem_h;

    tensor_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata (mem_rdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cfg_dtype = cfg_tdata[CFG_DTYPE_MSB:CFG_DTYPE_LSB];
    assign cfg_count = cfg_tdata[CFG_COUNT_MSB:CFG_COUNT_LSB];
    assign cfg_ok    = dtype_valid(cfg_dtype) && (cfg_count != '0);

    assign in_run     = (state == ST_RUN);
    assign cfg_tready = (state == ST_IDLE);
    assign cfg_fire   = cfg_tvalid && cfg_tready;

    // Only valid dtypes are ever latched, so lanes_per_word() is >= 1 here.
    assign lane_last_idx = lanes_per_word(dtype_q) - 3'd1;
    assign lane_is_last  = ({1'b0, lane} == lane_last_idx);
    // count_q is never zero while running, so count_q - 1 cannot wrap.
    assign elem_is_last  = (elem_cnt == count_q - COUNT_W'(1));

    assign out_tvalid = in_run && !fifo_empty;
    assign out_tlast  = out_tvalid && elem_is_last;
    assign out_fire   = out_tvalid && out_tready;

    // The head word leaves either when its last lane is consumed or when the
    // job ends mid-word, which discards the unused upper lanes.
    assign fifo_pop  = out_fire && (lane_is_last || elem_is_last);
    assign fifo_push = mem_rvalid && in_run;

    // A word is lost if it arrives while idle, or arrives into a full FIFO
    // that is not popping in the same cycle.
    assign word_dropped = (mem_rvalid && !in_run) ||
                          (fifo_push && fifo_full && !fifo_pop);

    assign fifo_afull   = (fifo_count >= AFULL_LEVEL);
    assign err_dtype    = err_dtype_q;
    assign err_overflow = err_overflow_q;

    // Lane select and extension. The head is zero-forced while not valid so
    // the data bus idles at zero instead of showing stale FIFO contents.
    always_comb begin
        elem_b   = fifo_head[{lane, 3'b000} +: 8];
        elem_h   = fifo_head[{lane[0], 4'b0000} +: 16];
        elem_ext = fifo_head;
        case (dtype_q)
            DT_INT8:  elem_ext = {{(WORD_W-8){elem_b[7]}}, elem_b};
            DT_INT16: elem_ext = {{(WORD_W-16){elem_h[15]}}, elem_h};
            default:  elem_ext = fifo_head;
        endcase
        out_tdata = out_tvalid ? elem_ext : '0;
    end

    // Job FSM: IDLE accepts a descriptor, RUN walks elements until tlast.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            dtype_q        <= DT_NONE;
            count_q        <= '0;
            elem_cnt       <= '0;
            lane           <= '0;
            err_dtype_q    <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            err_dtype_q <= 1'b0;
            if (word_dropped) begin
                err_overflow_q <= 1'b1;
            end
            if (state == ST_IDLE) begin
                if (cfg_fire) begin
                    if (cfg_ok) begin
                        dtype_q  <= dtype_e'(cfg_dtype);
                        count_q  <= cfg_count;
                        elem_cnt <= '0;
                        lane     <= '0;
                        state    <= ST_RUN;
                    end else begin
                        err_dtype_q <= 1'b1;
                    end
                end
            end else begin
                if (out_fire) begin
                    // elem_cnt stops at count_q - 1 <= 2^40 - 2; no wrap.
                    elem_cnt <= elem_cnt + COUNT_W'(1);
                    lane     <= lane_is_last ? 2'd0 : lane + 2'd1;
                    if (elem_is_last) begin
                        state <= ST_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tensor_unpacker.sv
// -----------------------------------------------------------------------------
// tb_tensor_unpacker
// Directed bench for tensor_unpacker. Stimulus pushes hand-computed expected
// beats into a queue; an independent monitor compares every output handshake
// against the queue head and also checks data stability during stalls.
// -----------------------------------------------------------------------------
module tb_tensor_unpacker;

    logic        clock = 1'b0;
    logic        reset;
    logic [42:0] cfg_tdata;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        fifo_afull;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        err_dtype;
    logic        err_overflow;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [32:0] exp_q [$];
    logic        stall_pending = 1'b0;
    logic [31:0] held_data     = '0;

    always #5 clock = ~clock;

    tensor_unpacker dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_tdata    (cfg_tdata),
        .cfg_tvalid   (cfg_tvalid),
        .cfg_tready   (cfg_tready),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .fifo_afull   (fifo_afull),
        .out_tdata    (out_tdata),
        .out_tvalid   (out_tvalid),
        .out_tready   (out_tready),
        .out_tlast    (out_tlast),
        .err_dtype    (err_dtype),
        .err_overflow (err_overflow)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_elem(input logic [31:0] data, input logic last);
        exp_q.push_back({last, data});
    endtask

    // Present one descriptor for a single cycle (always taken while idle).
    task automatic applyStimulus(input logic [2:0] dtype, input logic [39:0] count);
        @(posedge clock);
        #1;
        cfg_tdata  = {dtype, count};
        cfg_tvalid = 1'b1;
        @(posedge clock);
        #1;
        cfg_tvalid = 1'b0;
    endtask

    // One-cycle read return; consecutive calls produce back-to-back words.
    task automatic push_word(input logic [31:0] word);
        mem_rdata  = word;
        mem_rvalid = 1'b1;
        @(posedge clock);
        #1;
        mem_rvalid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        checkOutput({name, " beats left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(negedge clock);
    endtask

    // Monitor: compares every handshake with the scoreboard and checks that
    // a stalled beat keeps its data and valid until it is taken.
    always @(negedge clock) begin
        if (reset) begin
            stall_pending = 1'b0;
        end else if (out_tvalid) begin
            if (stall_pending) begin
                checkOutput("stall data stable", 64'(out_tdata), 64'(held_data));
            end
            if (out_tready) begin
                stall_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected beat: got data 0x%0h last %0b, expected none",
                             out_tdata, out_tlast);
                end else begin
                    checkOutput("beat {last,data}", 64'({out_tlast, out_tdata}),
                                64'(exp_q.pop_front()));
                end
            end else begin
                held_data     = out_tdata;
                stall_pending = 1'b1;
            end
        end else if (stall_pending) begin
            checkOutput("stall valid held", 64'(out_tvalid), 64'd1);
            stall_pending = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int occ;
        reset      = 1'b1;
        cfg_tdata  = '0;
        cfg_tvalid = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        out_tready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset cfg_tready",   64'(cfg_tready),   64'd1);
        checkOutput("reset out_tvalid",   64'(out_tvalid),   64'd0);
        checkOutput("reset out_tlast",    64'(out_tlast),    64'd0);
        checkOutput("reset out_tdata",    64'(out_tdata),    64'd0);
        checkOutput("reset fifo_afull",   64'(fifo_afull),   64'd0);
        checkOutput("reset err_dtype",    64'(err_dtype),    64'd0);
        checkOutput("reset err_overflow", 64'(err_overflow), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // int8, 6 elements; upper two lanes of the second word are discarded.
        expect_elem(32'h0000_0001, 1'b0);
        expect_elem(32'h0000_007F, 1'b0);
        expect_elem(32'h0000_0004, 1'b0);
        expect_elem(32'hFFFF_FF80, 1'b0);
        expect_elem(32'h0000_0002, 1'b0);
        expect_elem(32'h0000_0003, 1'b1);
        applyStimulus(3'd1, 40'd6);
        checkOutput("t1 cfg_tready in run", 64'(cfg_tready), 64'd0);
        push_word(32'h8004_7F01);
        push_word(32'h0000_0302);
        wait_drain(40, "t1");
        checkOutput("t1 idle after tlast", 64'(cfg_tready), 64'd1);
        checkOutput("t1 fifo empty",       64'(out_tvalid), 64'd0);

        // int16, 3 elements, out_tready toggling every cycle.
        expect_elem(32'h0000_1234, 1'b0);
        expect_elem(32'hFFFF_8000, 1'b0);
        expect_elem(32'h0000_7FFF, 1'b1);
        applyStimulus(3'd2, 40'd3);
        out_tready = 1'b0;
        fork
            begin
                push_word(32'h8000_1234);
                push_word(32'h0000_7FFF);
            end
            begin
                repeat (16) begin
                    @(posedge clock);
                    #1;
                    out_tready = ~out_tready;
                end
            end
        join
        out_tready = 1'b1;
        wait_drain(40, "t2");
        checkOutput("t2 idle after tlast", 64'(cfg_tready), 64'd1);

        // fp32, 10 elements, 10 back-to-back words while stalled.
        for (int i = 0; i < 8; i++) begin
            expect_elem(32'hA000_0000 + 32'(i), 1'b0);
        end
        expect_elem(32'hB000_0008, 1'b0);
        expect_elem(32'hB000_0009, 1'b1);
        out_tready = 1'b0;
        applyStimulus(3'd4, 40'd10);
        for (int i = 0; i < 10; i++) begin
            push_word(32'hA000_0000 + 32'(i));
            occ = (i + 1 > 8) ? 8 : i + 1;
            checkOutput($sformatf("t3 afull after word %0d", i + 1),
                        64'(fifo_afull), 64'(occ >= 5));
            checkOutput($sformatf("t3 overflow after word %0d", i + 1),
                        64'(err_overflow), 64'(i + 1 >= 9));
        end
        // FIFO is full: this word is only kept because a pop happens alongside.
        out_tready = 1'b1;
        push_word(32'hB000_0008);
        push_word(32'hB000_0009);
        wait_drain(40, "t3");
        checkOutput("t3 overflow sticky", 64'(err_overflow), 64'd1);
        checkOutput("t3 afull cleared",   64'(fifo_afull),   64'd0);
        checkOutput("t3 idle after tlast", 64'(cfg_tready),  64'd1);

        // Rejected descriptors: bad dtype, then zero count.
        applyStimulus(3'd6, 40'd5);
        checkOutput("t4 dtype6 err pulse",  64'(err_dtype),  64'd1);
        checkOutput("t4 dtype6 cfg_tready", 64'(cfg_tready), 64'd1);
        @(posedge clock);
        #1;
        checkOutput("t4 dtype6 err one cycle", 64'(err_dtype),  64'd0);
        checkOutput("t4 dtype6 still idle",    64'(cfg_tready), 64'd1);
        applyStimulus(3'd1, 40'd0);
        checkOutput("t4 count0 err pulse",  64'(err_dtype),  64'd1);
        checkOutput("t4 count0 cfg_tready", 64'(cfg_tready), 64'd1);
        @(posedge clock);
        #1;
        checkOutput("t4 count0 err one cycle", 64'(err_dtype),  64'd0);
        checkOutput("t4 count0 no beat",       64'(out_tvalid), 64'd0);

        // Reset on the 3rd element of a 20-element int32 job.
        expect_elem(32'hC000_0000, 1'b0);
        expect_elem(32'hC000_0001, 1'b0);
        expect_elem(32'hC000_0002, 1'b0);
        out_tready = 1'b0;
        applyStimulus(3'd3, 40'd20);
        for (int i = 0; i < 5; i++) begin
            push_word(32'hC000_0000 + 32'(i));
        end
        out_tready = 1'b1;
        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(negedge clock);
                #1;
                n++;
            end
        end
        checkOutput("t5 beats before reset", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("t5 out_tvalid after reset",   64'(out_tvalid),   64'd0);
        checkOutput("t5 out_tlast after reset",    64'(out_tlast),    64'd0);
        checkOutput("t5 out_tdata after reset",    64'(out_tdata),    64'd0);
        checkOutput("t5 cfg_tready after reset",   64'(cfg_tready),   64'd1);
        checkOutput("t5 overflow cleared",         64'(err_overflow), 64'd0);
        checkOutput("t5 afull after reset",        64'(fifo_afull),   64'd0);
        reset = 1'b0;

        // Fresh job after the flush: no stale words may appear.
        expect_elem(32'hD000_0001, 1'b0);
        expect_elem(32'hD000_0002, 1'b1);
        applyStimulus(3'd3, 40'd2);
        push_word(32'hD000_0001);
        push_word(32'hD000_0002);
        wait_drain(40, "t5 new job");
        checkOutput("t5 new job idle", 64'(cfg_tready), 64'd1);

        // A returned word while idle is dropped and flagged.
        push_word(32'h1234_5678);
        checkOutput("t6 idle word overflow", 64'(err_overflow), 64'd1);
        checkOutput("t6 idle word no beat",  64'(out_tvalid),   64'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
